// File: rtl/bdpsk_pkg.sv
// Shared definitions for the BDPSK frame sequencer: segment states and default
// timing/sync constants.
package bdpsk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    TAIL
  } state_t;

  localparam int          DEF_CLK_DIV   = 8;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hF3A0;

endpackage

// File: rtl/bdpsk_frame_ctrl_if.sv
// Payload byte stream into the frame sequencer (valid/ready handshake).
interface bdpsk_frame_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bdpsk_baud_gen.sv
// Bit-rate divider: free-runs 0..CLK_DIV-1 while enabled, strobes on the last count.
module bdpsk_baud_gen
  import bdpsk_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic strobe
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (clear) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign strobe = enable && (div == DIV_LAST);

endmodule

// File: rtl/bdpsk_frame_ctrl.sv
// Frame sequencer ahead of the BDPSK encoder: preamble, sync word, payload bytes
// (MSB first, from a one-byte holding register) and zero tail, one bit per strobe.
module bdpsk_frame_ctrl
  import bdpsk_pkg::*;
#(
  parameter int          CLK_DIV       = DEF_CLK_DIV,
  parameter int          PREAMBLE_BITS = 32,
  parameter int          SYNC_BITS     = 16,
  parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int          TAIL_BITS     = 8,
  parameter int          LEN_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  bdpsk_frame_ctrl_if.slave    byte_if,
  output logic                 bit_strobe,
  output logic                 bit_data,
  output logic                 dif_init,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 underrun
);

  localparam int CNT_W = 16;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   len_q, byte_cnt, fetched, fetched_nxt;
  logic [LEN_W+1:0]   fetch_sum;
  logic [7:0]         hold_data, shreg;
  logic               hold_full;
  logic               start_acc, last_bit, last_byte, load, xfer;
  logic [3:0]         sync_idx;

  assign start_acc = start && (state == IDLE);

  bdpsk_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .clear  (start_acc),
    .strobe (bit_strobe)
  );

  always_comb begin
    last_bit = 1'b0;
    case (state)
      PREAMBLE: last_bit = (bit_cnt == CNT_W'(PREAMBLE_BITS - 1));
      SYNC:     last_bit = (bit_cnt == CNT_W'(SYNC_BITS - 1));
      PAYLOAD:  last_bit = (bit_cnt == CNT_W'(7));
      TAIL:     last_bit = (bit_cnt == CNT_W'(TAIL_BITS - 1));
      default:  last_bit = 1'b0;
    endcase
  end

  assign last_byte = (byte_cnt == len_q - LEN_W'(1));
  assign xfer      = byte_if.in_valid && byte_if.in_ready;

  // Shift register reloads at the end of sync and of every payload byte but the final one.
  assign load = bit_strobe && last_bit &&
                ((state == SYNC && len_q != '0) || (state == PAYLOAD && !last_byte));

  // An empty holding register at load time still consumes a slot, so it counts as fetched.
  assign fetch_sum   = {2'b00, fetched} + (LEN_W+2)'(xfer) + (LEN_W+2)'(load && !hold_full);
  assign fetched_nxt = (fetch_sum >= {2'b00, len_q}) ? len_q : fetch_sum[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = PREAMBLE;
      PREAMBLE: if (bit_strobe && last_bit) state_nxt = SYNC;
      SYNC:     if (bit_strobe && last_bit) state_nxt = (len_q == '0) ? TAIL : PAYLOAD;
      PAYLOAD:  if (bit_strobe && last_bit && last_byte) state_nxt = TAIL;
      TAIL:     if (bit_strobe && last_bit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != IDLE);
    byte_if.in_ready = (state == SYNC || state == PAYLOAD) && !hold_full && (fetched < len_q);
    sync_idx         = 4'(SYNC_BITS - 1) - bit_cnt[3:0];
    bit_data         = 1'b0;
    case (state)
      PREAMBLE: bit_data = ~bit_cnt[0];
      SYNC:     bit_data = SYNC_WORD[sync_idx];
      PAYLOAD:  bit_data = shreg[7];
      default:  bit_data = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      len_q      <= '0;
      byte_cnt   <= '0;
      fetched    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      dif_init   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dif_init   <= start_acc;
      frame_done <= (state == TAIL) && bit_strobe && last_bit;
      if (start_acc) begin
        len_q     <= frame_len;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        fetched   <= '0;
        hold_full <= 1'b0;
        shreg     <= '0;
        underrun  <= 1'b0;
      end else begin
        if (bit_strobe) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        end
        if (bit_strobe && state == PAYLOAD && last_bit) begin
          byte_cnt <= byte_cnt + LEN_W'(1);
        end
        fetched <= fetched_nxt;
        if (load) begin
          if (hold_full) begin
            shreg <= hold_data;
          end else begin
            shreg    <= '0;
            underrun <= 1'b1;
          end
        end else if (bit_strobe && state == PAYLOAD) begin
          shreg <= {shreg[6:0], 1'b0};
        end
        if (xfer) begin
          hold_full <= 1'b1;
          hold_data <= byte_if.in_data;
        end else if (load) begin
          hold_full <= 1'b0;
        end
      end
    end
  end

endmodule
